// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared constants and types for the 4-digit 7-segment display
//                path: cathode patterns, digit-enable codes, capture FSM
//                state encoding and display timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    // Active-low cathode patterns on seg[6:0] (g..a), decimal point excluded
    localparam logic [6:0] SEG_PAT_0 = 7'h40;
    localparam logic [6:0] SEG_PAT_1 = 7'h79;
    localparam logic [6:0] SEG_PAT_2 = 7'h24;
    localparam logic [6:0] SEG_PAT_3 = 7'h30;
    localparam logic [6:0] SEG_PAT_4 = 7'h19;
    localparam logic [6:0] SEG_PAT_5 = 7'h12;
    localparam logic [6:0] SEG_PAT_6 = 7'h02;
    localparam logic [6:0] SEG_PAT_7 = 7'h78;
    localparam logic [6:0] SEG_PAT_8 = 7'h00;
    localparam logic [6:0] SEG_PAT_9 = 7'h18;

    // One-cold digit enables, most significant digit first
    localparam logic [3:0] DIG_THOUSANDS = 4'b0111;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b1011;
    localparam logic [3:0] DIG_TENS      = 4'b1101;
    localparam logic [3:0] DIG_UNITS     = 4'b1110;
    localparam logic [3:0] DIG_BLANK     = 4'b1111;

    // Driver dwell per digit in 100 MHz clocks
    localparam int SEG_PERIOD_2MS = 200000;

    // Capture FSM: the numeric value of EXPn equals the slot it expects next
    typedef enum logic [1:0] {
        ST_WAIT0 = 2'd0,
        ST_EXP1  = 2'd1,
        ST_EXP2  = 2'd2,
        ST_EXP3  = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] slot;
    } slot_t;

    // Map a one-cold digit enable to its slot index (0 = thousands)
    function automatic slot_t dig_to_slot(input logic [3:0] dig_code);
        slot_t r;
        r.legal = 1'b1;
        r.slot  = 2'd0;
        case (dig_code)
            DIG_THOUSANDS: r.slot = 2'd0;
            DIG_HUNDREDS:  r.slot = 2'd1;
            DIG_TENS:      r.slot = 2'd2;
            DIG_UNITS:     r.slot = 2'd3;
            default:       r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pattern_decode
//  Description : Combinational decode of an active-low cathode pattern back to
//                a decimal digit, flagging any pattern that is not 0-9.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic [3:0] o_value
);

    // Pattern lookup; anything outside the ten digit glyphs is invalid
    always_comb begin
        o_valid = 1'b1;
        o_value = 4'd0;
        case (i_seg)
            SEG_PAT_0: o_value = 4'd0;
            SEG_PAT_1: o_value = 4'd1;
            SEG_PAT_2: o_value = 4'd2;
            SEG_PAT_3: o_value = 4'd3;
            SEG_PAT_4: o_value = 4'd4;
            SEG_PAT_5: o_value = 4'd5;
            SEG_PAT_6: o_value = 4'd6;
            SEG_PAT_7: o_value = 4'd7;
            SEG_PAT_8: o_value = 4'd8;
            SEG_PAT_9: o_value = 4'd9;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_capture
//  Description : Samples a multiplexed 4-digit 7-segment bus, decodes each
//                digit and reports the complete frame as BCD and binary with a
//                one-cycle valid strobe, plus segment/frame error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig,
    output logic [15:0] number,
    output logic [15:0] bcd,
    output logic        number_valid,
    output logic        seg_error,
    output logic        frame_error
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] c_stable_max  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] c_stable_pre  = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] c_timeout_max = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]   c_sync_idle   = {DIG_BLANK, 8'hFF};

    logic [11:0]      r_sync1, r_sync2;
    logic [SW-1:0]    r_stable_cnt;
    logic [TW-1:0]    r_to_cnt;
    cap_state_t       r_state, w_state_next;
    logic [3:0][3:0]  r_digits;
    logic [3:0]       w_store;
    logic             w_changed, w_sample, w_timeout;
    logic             w_done, w_seg_err, w_frame_err;
    logic             r_done, r_valid, r_seg_err, r_frame_err;
    logic [15:0]      r_number, r_bcd, w_number;
    logic [15:0]      w_th, w_hu, w_te, w_un;
    logic [3:0]       w_dig;
    logic             w_pat_valid;
    logic [3:0]       w_pat_value;
    slot_t            w_slot;
    logic [1:0]       w_last_slot;
    logic             w_unused_dp;

    assign w_dig       = r_sync2[11:8];
    assign w_unused_dp = r_sync2[7];
    assign w_slot      = dig_to_slot(w_dig);
    assign w_last_slot = 2'(r_state) - 2'd1;

    // The change test looks one stage ahead so the counter restarts in the
    // same cycle the new value reaches the second stage
    assign w_changed = (r_sync1 != r_sync2);
    assign w_sample  = !w_changed && (r_stable_cnt == c_stable_pre);
    assign w_timeout = (r_state != ST_WAIT0) && !w_sample && (r_to_cnt == c_timeout_max);

    sevenseg_pattern_decode u_decode (
        .i_seg   (r_sync2[6:0]),
        .o_valid (w_pat_valid),
        .o_value (w_pat_value)
    );

    // Two-flop synchronizer for the asynchronous display bus
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= c_sync_idle;
            r_sync2 <= c_sync_idle;
        end else begin
            r_sync1 <= {dig, seg};
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: restart on change, saturate once the value has settled
    always_ff @(posedge clk) begin
        if (!rst_n || w_changed) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != c_stable_max) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // Inter-sample timeout, only armed while a frame is in progress
    always_ff @(posedge clk) begin
        if (!rst_n || w_sample || w_timeout || r_state == ST_WAIT0) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_WAIT0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame sequencing: decides which slot to store and which error to raise
    always_comb begin
        w_state_next = r_state;
        w_store      = 4'b0000;
        w_done       = 1'b0;
        w_seg_err    = 1'b0;
        w_frame_err  = 1'b0;
        if (w_sample) begin
            if (w_dig == DIG_BLANK) begin
                w_state_next = r_state;
            end else if (!w_slot.legal) begin
                w_frame_err  = 1'b1;
                w_state_next = ST_WAIT0;
            end else if (!w_pat_valid) begin
                w_seg_err    = 1'b1;
                w_state_next = ST_WAIT0;
            end else if (w_slot.slot == 2'd0) begin
                w_store[0]   = 1'b1;
                w_state_next = ST_EXP1;
            end else if (r_state != ST_WAIT0) begin
                if (w_slot.slot == 2'(r_state)) begin
                    w_store[w_slot.slot] = 1'b1;
                    case (r_state)
                        ST_EXP1: w_state_next = ST_EXP2;
                        ST_EXP2: w_state_next = ST_EXP3;
                        default: begin
                            w_state_next = ST_WAIT0;
                            w_done       = 1'b1;
                        end
                    endcase
                end else if (w_slot.slot == w_last_slot) begin
                    w_store[w_slot.slot] = 1'b1;
                end else begin
                    w_frame_err  = 1'b1;
                    w_state_next = ST_WAIT0;
                end
            end
        end else if (w_timeout) begin
            w_frame_err  = 1'b1;
            w_state_next = ST_WAIT0;
        end
    end

    // Per-slot digit storage, index 0 = thousands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digits <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_store[i]) begin
                    r_digits[i] <= w_pat_value;
                end
            end
        end
    end

    // Decimal to binary by constant shift-add: 1000=1024-16-8, 100=64+32+4, 10=8+2
    assign w_th = {12'd0, r_digits[0]};
    assign w_hu = {12'd0, r_digits[1]};
    assign w_te = {12'd0, r_digits[2]};
    assign w_un = {12'd0, r_digits[3]};
    assign w_number = (w_th << 10) - (w_th << 4) - (w_th << 3)
                    + (w_hu << 6) + (w_hu << 5) + (w_hu << 2)
                    + (w_te << 3) + (w_te << 1) + w_un;

    // Output stage: result registered the cycle after completion, strobe after that
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_seg_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_number    <= '0;
            r_bcd       <= '0;
        end else begin
            r_done      <= w_done;
            r_valid     <= r_done;
            r_seg_err   <= w_seg_err;
            r_frame_err <= w_frame_err;
            if (r_done) begin
                r_number <= w_number;
                r_bcd    <= {r_digits[0], r_digits[1], r_digits[2], r_digits[3]};
            end
        end
    end

    assign number       = r_number;
    assign bcd          = r_bcd;
    assign number_valid = r_valid;
    assign seg_error    = r_seg_err;
    assign frame_error  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevenseg_capture
//  Description : Self-checking bench for sevenseg_capture. Expected frames are
//                queued as they are driven and compared when number_valid fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg   = 8'hFF;
    logic [3:0]  dig   = 4'hF;
    logic [15:0] number, bcd;
    logic        number_valid, seg_error, frame_error;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_seg = 0;
    int n_frm = 0;
    int exp_q[$];
    int drv_q[$];

    sevenseg_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg          (seg),
        .dig          (dig),
        .number       (number),
        .bcd          (bcd),
        .number_valid (number_valid),
        .seg_error    (seg_error),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    // Posedge count used to measure strobe latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h18;
        endcase
    endfunction

    function automatic logic [3:0] dcode(input int slot);
        case (slot)
            0: return 4'b0111;
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] a, b, c, d;
        a = 4'(v / 1000);
        b = 4'((v / 100) % 10);
        c = 4'((v / 10) % 10);
        d = 4'(v % 10);
        return {a, b, c, d};
    endfunction

    // Strobe monitor: pops the scoreboard and counts error pulses
    always @(negedge clk) begin : mon
        int e, t;
        if (seg_error)   n_seg++;
        if (frame_error) n_frm++;
        if (number_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check_value("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = drv_q.pop_front();
                check_value("number", 32'(number), 32'(e));
                check_value("bcd", 32'(bcd), 32'(to_bcd(e)));
                check_value("valid_latency", 32'(cyc - t), 32'(STABLE + 2));
            end
        end
    end

    // Present a dig/seg combination for n clocks (called at a negedge)
    task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
        dig = d;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int slot, input int val, input int n, input bit dp_toggle);
        if (dp_toggle) begin
            drive(dcode(slot), {1'b1, pat(val)}, 8);
            drive(dcode(slot), {1'b0, pat(val)}, 4);
        end else begin
            drive(dcode(slot), {1'b1, pat(val)}, n);
        end
    endtask

    task automatic frame(input int a, input int b, input int c, input int d, input bit dp_toggle);
        digit(0, a, 10, dp_toggle);
        digit(1, b, 10, dp_toggle);
        digit(2, c, 10, dp_toggle);
        exp_q.push_back(a * 1000 + b * 100 + c * 10 + d);
        drv_q.push_back(cyc);
        digit(3, d, 10, dp_toggle);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_number", 32'(number), 32'd0);
        check_value("rst_bcd", 32'(bcd), 32'd0);
        check_value("rst_valid", 32'(number_valid), 32'd0);
        check_value("rst_seg_error", 32'(seg_error), 32'd0);
        check_value("rst_frame_error", 32'(frame_error), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Basic frame 1234
        frame(1, 2, 3, 4, 1'b0);
        repeat (5) @(negedge clk);
        check_value("valid_count_1234", 32'(n_valid), 32'd1);

        // Three frames of 9999 with decimal point toggling
        for (int i = 0; i < 3; i++) frame(9, 9, 9, 9, 1'b1);
        repeat (5) @(negedge clk);
        check_value("valid_count_9999", 32'(n_valid), 32'd4);
        check_value("frame_err_none", 32'(n_frm), 32'd0);

        // Skipped hundreds digit
        digit(0, 5, 10, 1'b0);
        digit(2, 3, 10, 1'b0);
        check_value("skip_frame_error", 32'(n_frm), 32'd1);
        check_value("skip_no_valid", 32'(n_valid), 32'd4);
        check_value("skip_number_hold", 32'(number), 32'd9999);

        // Undecodable units pattern, then a clean frame
        digit(0, 0, 10, 1'b0);
        digit(1, 0, 10, 1'b0);
        digit(2, 0, 10, 1'b0);
        drive(dcode(3), 8'hFF, 10);
        check_value("bad_pattern_seg_error", 32'(n_seg), 32'd1);
        check_value("bad_pattern_number_hold", 32'(number), 32'd9999);
        frame(0, 0, 0, 7, 1'b0);
        repeat (5) @(negedge clk);
        check_value("after_seg_err_valid", 32'(n_valid), 32'd5);

        // Timeout while holding hundreds
        digit(0, 1, 10, 1'b0);
        digit(1, 2, 150, 1'b0);
        check_value("timeout_frame_error", 32'(n_frm), 32'd2);
        check_value("timeout_number_hold", 32'(number), 32'd7);

        // Short glitch on the units position before the real units digit
        digit(0, 5, 10, 1'b0);
        digit(1, 6, 10, 1'b0);
        digit(2, 7, 10, 1'b0);
        drive(dcode(3), {1'b1, pat(0)}, 2);
        exp_q.push_back(5678);
        drv_q.push_back(cyc);
        digit(3, 8, 10, 1'b0);
        repeat (5) @(negedge clk);
        check_value("glitch_valid_count", 32'(n_valid), 32'd6);

        // Reset in the middle of a frame
        digit(0, 1, 10, 1'b0);
        digit(1, 2, 10, 1'b0);
        digit(2, 3, 10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_value("midrst_number", 32'(number), 32'd0);
        check_value("midrst_bcd", 32'(bcd), 32'd0);
        repeat (10) @(negedge clk);
        check_value("midrst_no_valid", 32'(n_valid), 32'd6);
        check_value("midrst_no_seg_err", 32'(n_seg), 32'd1);
        check_value("midrst_no_frm_err", 32'(n_frm), 32'd2);
        frame(4, 0, 9, 6, 1'b0);
        repeat (10) @(negedge clk);

        // Totals
        check_value("final_valid_count", 32'(n_valid), 32'd7);
        check_value("final_seg_err_count", 32'(n_seg), 32'd1);
        check_value("final_frm_err_count", 32'(n_frm), 32'd2);
        check_value("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_value("final_number", 32'(number), 32'd4096);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
